// File: rtl/divider_defs.sv
// rtl/divider_defs.sv - shared state encodings and default width for the divider
package divider_defs;

    localparam int DIV_WIDTH = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        CHECK  = 3'd3,
        ITER   = 3'd4,
        FIX    = 3'd5,
        OUT_Q  = 3'd6,
        OUT_R  = 3'd7
    } div_state_t;

endpackage

// File: rtl/div_datapath.sv
// rtl/div_datapath.sv - operand/remainder/quotient registers, restoring step, sign fix-up, result mux
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   load_a, load_b  capture data_in as dividend / divisor
//   check           take signs and magnitudes, evaluate divide-by-zero and overflow
//   shift           one restoring iteration (one quotient bit)
//   fix             apply signs and special cases to the results
//   done, sel       result beat qualifier and select (0 = quotient, 1 = remainder)
//   data_in         operand bus
//   data_out        result bus, 0 when done is low
//   dvz, ovf        flags, gated by done
module div_datapath
    import divider_defs::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_a,
    input  logic             load_b,
    input  logic             check,
    input  logic             shift,
    input  logic             fix,
    input  logic             done,
    input  logic             sel,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             dvz,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] q;
    logic             sign_q;
    logic             sign_r;
    logic             dvz_r;
    logic             ovf_r;
    logic [WIDTH-1:0] quo_res;
    logic [WIDTH-1:0] rem_res;

    logic [WIDTH-1:0] dvd_mag_c;
    logic [WIDTH-1:0] dvs_mag_c;
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] diff;
    logic             keep;

    // The most-negative operand negates to itself, which read unsigned is exactly 2^(WIDTH-1).
    assign dvd_mag_c = dvd[WIDTH-1] ? -dvd : dvd;
    assign dvs_mag_c = dvs[WIDTH-1] ? -dvs : dvs;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    assign rem_sh = {rem, q[WIDTH-1]};
    assign diff   = rem_sh - {2'b00, dvs_mag};
    assign keep   = (rem_sh >= {2'b00, dvs_mag});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd     <= '0;
            dvs     <= '0;
            dvs_mag <= '0;
            rem     <= '0;
            q       <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            dvz_r   <= 1'b0;
            ovf_r   <= 1'b0;
            quo_res <= '0;
            rem_res <= '0;
        end else begin
            if (load_a) begin
                dvd <= data_in;
            end
            if (load_b) begin
                dvs <= data_in;
            end
            if (check) begin
                sign_q  <= dvd[WIDTH-1] ^ dvs[WIDTH-1];
                sign_r  <= dvd[WIDTH-1];
                q       <= dvd_mag_c;
                dvs_mag <= dvs_mag_c;
                rem     <= '0;
                dvz_r   <= (dvs == '0);
                ovf_r   <= (dvd == MIN_NEG) && (dvs == '1);
            end
            if (shift) begin
                // Partial remainder stays below the divisor magnitude, so truncation loses nothing.
                rem <= keep ? (WIDTH+1)'(diff) : (WIDTH+1)'(rem_sh);
                q   <= {q[WIDTH-2:0], keep};
            end
            if (fix) begin
                if (dvz_r) begin
                    quo_res <= '1;
                    rem_res <= dvd;
                end else if (ovf_r) begin
                    quo_res <= MIN_NEG;
                    rem_res <= '0;
                end else begin
                    quo_res <= sign_q ? -q : q;
                    rem_res <= sign_r ? WIDTH'(-rem) : WIDTH'(rem);
                end
            end
        end
    end

    assign data_out = done ? (sel ? rem_res : quo_res) : '0;
    assign dvz      = done & dvz_r;
    assign ovf      = done & ovf_r;

endmodule

// File: rtl/booth_divider.sv
// rtl/booth_divider.sv - sequential signed restoring divider, serial operand load, two-beat result
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   start     begin a division (sampled only in IDLE)
//   data_in   dividend in LOAD_A, divisor in LOAD_B
//   data_out  quotient (sel=0) then remainder (sel=1) while done, else 0
//   sel       result beat select
//   done      high in OUT_Q and OUT_R
//   busy      high in every state except IDLE
//   dvz       divide-by-zero flag, valid while done
//   ovf       most-negative / -1 overflow flag, valid while done
module booth_divider
    import divider_defs::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             sel,
    output logic             done,
    output logic             busy,
    output logic             dvz,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    div_state_t    state;
    div_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    logic load_a;
    logic load_b;
    logic check;
    logic shift;
    logic fix;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_a    = 1'b0;
        load_b    = 1'b0;
        check     = 1'b0;
        shift     = 1'b0;
        fix       = 1'b0;
        done      = 1'b0;
        sel       = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = LOAD_A;
                end
            end
            LOAD_A: begin
                load_a    = 1'b1;
                state_nxt = LOAD_B;
            end
            LOAD_B: begin
                load_b    = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
                check     = 1'b1;
                cnt_nxt   = '0;
                state_nxt = ITER;
            end
            ITER: begin
                shift = 1'b1;
                if (cnt == LAST_ITER) begin
                    cnt_nxt   = '0;
                    state_nxt = FIX;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            FIX: begin
                fix       = 1'b1;
                state_nxt = OUT_Q;
            end
            OUT_Q: begin
                done      = 1'b1;
                state_nxt = OUT_R;
            end
            OUT_R: begin
                done      = 1'b1;
                sel       = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    div_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .load_a   (load_a),
        .load_b   (load_b),
        .check    (check),
        .shift    (shift),
        .fix      (fix),
        .done     (done),
        .sel      (sel),
        .data_in  (data_in),
        .data_out (data_out),
        .dvz      (dvz),
        .ovf      (ovf)
    );

endmodule

// File: tb/tb_booth_divider.sv
// tb/tb_booth_divider.sv - directed-vector self-checking bench for booth_divider
module tb_booth_divider;

    localparam int W = 5;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] data_in;
    logic [W-1:0] data_out;
    logic         sel;
    logic         done;
    logic         busy;
    logic         dvz;
    logic         ovf;

    int n_vec;
    int n_bad;

    booth_divider #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .data_out (data_out),
        .sel      (sel),
        .done     (done),
        .busy     (busy),
        .dvz      (dvz),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one division; poke drives a start pulse during cycle 5 (busy).
    task automatic run_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic edvz, input logic eovf, input logic poke);
        int cyc;
        @(negedge clk);
        start   = 1'b1;
        data_in = W'($urandom);
        @(negedge clk);
        start   = 1'b0;
        data_in = a;
        @(negedge clk);
        data_in = b;
        @(negedge clk);
        data_in = W'($urandom);
        cyc = 3;
        while (!done && cyc < 40) begin
            start = (poke && cyc == 5);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check_val({name, " latency"}, cyc, 10);
        check_val({name, " q"}, {sel, data_out}, {1'b0, eq});
        check_val({name, " q flags"}, {done, busy, dvz, ovf}, {1'b1, 1'b1, edvz, eovf});
        @(negedge clk);
        check_val({name, " r"}, {sel, data_out}, {1'b1, er});
        check_val({name, " r flags"}, {done, busy, dvz, ovf}, {1'b1, 1'b1, edvz, eovf});
        @(negedge clk);
        check_val({name, " idle"}, {done, busy, dvz, ovf, data_out}, '0);
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        rst     = 1'b0;
        start   = 1'b0;
        data_in = '0;
        repeat (2) @(negedge clk);
        check_val("reset outputs", {data_out, sel, done, busy, dvz, ovf}, '0);
        rst = 1'b1;

        run_div("13/4",   5'b01101, 5'b00100, 5'b00011, 5'b00001, 1'b0, 1'b0, 1'b0);
        run_div("-13/4",  5'b10011, 5'b00100, 5'b11101, 5'b11111, 1'b0, 1'b0, 1'b0);
        run_div("13/-4",  5'b01101, 5'b11100, 5'b11101, 5'b00001, 1'b0, 1'b0, 1'b0);
        run_div("7/0",    5'b00111, 5'b00000, 5'b11111, 5'b00111, 1'b1, 1'b0, 1'b0);
        run_div("-16/-1", 5'b10000, 5'b11111, 5'b10000, 5'b00000, 1'b0, 1'b1, 1'b0);
        run_div("-16/1",  5'b10000, 5'b00001, 5'b10000, 5'b00000, 1'b0, 1'b0, 1'b0);
        run_div("15/-16", 5'b01111, 5'b10000, 5'b00000, 5'b01111, 1'b0, 1'b0, 1'b0);
        run_div("-16/3",  5'b10000, 5'b00011, 5'b11011, 5'b11111, 1'b0, 1'b0, 1'b0);

        // Abort during the third ITER cycle (cycle 6 after the start edge).
        @(negedge clk);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        data_in = 5'b01101;
        @(negedge clk);
        data_in = 5'b00100;
        repeat (4) @(negedge clk);
        check_val("pre-abort busy", {busy, done}, 2'b10);
        rst = 1'b0;
        #1;
        check_val("abort outputs", {data_out, sel, done, busy, dvz, ovf}, '0);
        @(negedge clk);
        rst = 1'b1;

        run_div("13/4 after reset", 5'b01101, 5'b00100, 5'b00011, 5'b00001, 1'b0, 1'b0, 1'b0);
        run_div("13/4 start poke",  5'b01101, 5'b00100, 5'b00011, 5'b00001, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
